// File: rtl/axi_lite_xbar_if.sv
// axi_lite_xbar_if: AXI4-Lite bundle whose valid/ready lanes, read data and responses are NS wide.
// Address, write data and strobe are single copies.
// NS=1 describes the upstream master link; NS>1 describes the slave fan-out.
// Ports: none.
// Modports:
//   master - drives AR/AW/W and R/B ready.
//   slave  - drives the AR/AW/W ready signals and the R/B channels.
interface axi_lite_xbar_if #(parameter int NS = 1);
    logic [NS-1:0]    arvalid, arready;
    logic [31:0]      araddr;
    logic [NS-1:0]    rvalid, rready;
    logic [32*NS-1:0] rdata;
    logic [2*NS-1:0]  rresp;
    logic [NS-1:0]    awvalid, awready;
    logic [31:0]      awaddr;
    logic [NS-1:0]    wvalid, wready;
    logic [31:0]      wdata;
    logic [3:0]       wstrb;
    logic [NS-1:0]    bvalid, bready;
    logic [2*NS-1:0]  bresp;
    modport master(output arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
                   input arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp);
    modport slave(input arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
                  output arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp);
endinterface

// File: rtl/axi_lite_xbar.sv
// axi_lite_xbar: 1-master, NS-slave AXI4-Lite crossbar with one outstanding transaction.
// An internal responder answers unmapped addresses with DECERR.
// Ports:
//   clk   - clock
//   rst_n - asynchronous reset, active low
//   m     - upstream master link (NS=1 interface, slave modport)
//   s     - slave fan-out (NS-wide interface, master modport); address and write data are broadcast
module axi_lite_xbar #(
    parameter int              NS       = 3,
    parameter logic [32*NS-1:0] SLV_BASE = {32'hA000_0048, 32'hA000_03F8, 32'h8000_0000},
    parameter logic [32*NS-1:0] SLV_MASK = {32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hF800_0000}
) (
    input  logic              clk,
    input  logic              rst_n,
    axi_lite_xbar_if.slave    m,
    axi_lite_xbar_if.master   s
);
    localparam int SW = NS > 1 ? $clog2(NS) : 1;
    typedef enum logic [3:0] {IDLE, RD_A, RD_D, WR_AW, WR_B, ERR_RA, ERR_RD, ERR_WA, ERR_WB} state_e;
    state_e        state_q, state_d;
    logic [SW-1:0] sel_q, sel_d;
    logic          aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [NS-1:0] sel_oh;
    logic [SW:0]   rd_dec, wr_dec;
    logic          aw_hs, w_hs;
    // Returns {miss, index}. Scanning from the top lets the lowest hitting index win.
    function automatic logic [SW:0] decode(input logic [31:0] a);
        logic [SW:0] r = {1'b1, {SW{1'b0}}};
        for (int i = NS - 1; i >= 0; i--)
            r = ((a & SLV_MASK[32*i+:32]) == SLV_BASE[32*i+:32]) ? {1'b0, SW'(i)} : r;
        return r;
    endfunction
    always_comb begin
        sel_oh   = NS'(1) << sel_q;
        rd_dec   = decode(m.araddr);
        // A write may open with W alone, so the decode relies on awaddr already being stable.
        wr_dec   = decode(m.awaddr);
        aw_hs    = m.awvalid & !aw_done_q & ((state_q == ERR_WA) | ((state_q == WR_AW) & s.awready[sel_q]));
        w_hs     = m.wvalid & !w_done_q & ((state_q == ERR_WA) | ((state_q == WR_AW) & s.wready[sel_q]));
        m.arready = ((state_q == RD_A) & s.arready[sel_q]) | (state_q == ERR_RA);
        m.rvalid  = (state_q == RD_D) ? s.rvalid[sel_q] : (state_q == ERR_RD);
        m.rdata   = (state_q == RD_D) ? s.rdata[{sel_q, 5'd0} +: 32] : '0;
        m.rresp   = (state_q == RD_D) ? s.rresp[{sel_q, 1'b0} +: 2] : {2{state_q == ERR_RD}};
        m.awready = !aw_done_q & ((state_q == ERR_WA) | ((state_q == WR_AW) & s.awready[sel_q]));
        m.wready  = !w_done_q & ((state_q == ERR_WA) | ((state_q == WR_AW) & s.wready[sel_q]));
        m.bvalid  = (state_q == WR_B) ? s.bvalid[sel_q] : (state_q == ERR_WB);
        m.bresp   = (state_q == WR_B) ? s.bresp[{sel_q, 1'b0} +: 2] : {2{state_q == ERR_WB}};
        s.arvalid = sel_oh & {NS{(state_q == RD_A) & m.arvalid}};
        s.araddr  = m.araddr;
        s.rready  = sel_oh & {NS{(state_q == RD_D) & m.rready}};
        s.awvalid = sel_oh & {NS{(state_q == WR_AW) & m.awvalid & !aw_done_q}};
        s.awaddr  = m.awaddr;
        s.wvalid  = sel_oh & {NS{(state_q == WR_AW) & m.wvalid & !w_done_q}};
        s.wdata   = m.wdata;
        s.wstrb   = m.wstrb;
        s.bready  = sel_oh & {NS{(state_q == WR_B) & m.bready}};
    end
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        case (state_q)
            IDLE: begin
                if (m.awvalid | m.wvalid) begin
                    state_d   = wr_dec[SW] ? ERR_WA : WR_AW;
                    sel_d     = wr_dec[SW-1:0];
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end else if (m.arvalid) begin
                    state_d = rd_dec[SW] ? ERR_RA : RD_A;
                    sel_d   = rd_dec[SW-1:0];
                end
            end
            RD_A:    if (m.arvalid & s.arready[sel_q]) state_d = RD_D;
            RD_D:    if (m.rready & s.rvalid[sel_q]) state_d = IDLE;
            WR_AW:   if (aw_done_d & w_done_d) state_d = WR_B;
            WR_B:    if (m.bready & s.bvalid[sel_q]) state_d = IDLE;
            ERR_RA:  state_d = ERR_RD;
            ERR_RD:  if (m.rready) state_d = IDLE;
            ERR_WA:  if (aw_done_d & w_done_d) state_d = ERR_WB;
            ERR_WB:  if (m.bready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end
endmodule

// File: tb/tb_axi_lite_xbar.sv
// tb_axi_lite_xbar: self-checking bench for axi_lite_xbar with three behavioural slaves and an R/B scoreboard.
// Ports: none.
module tb_axi_lite_xbar;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    axi_lite_xbar_if #(.NS(1)) mif();
    axi_lite_xbar_if #(.NS(3)) sif();

    axi_lite_xbar #(
        .NS(3),
        .SLV_BASE({32'hA000_0048, 32'hA000_03F8, 32'h8000_0000}),
        .SLV_MASK({32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hF800_0000})
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .m(mif.slave),
        .s(sif.master)
    );

    typedef struct {logic [31:0] data; logic [1:0] resp;} rexp_t;
    typedef struct {
        logic wr; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb;
        int lat; int es; logic [31:0] rdata; logic [1:0] resp;
    } vec_t;

    rexp_t      rq[$];
    logic [1:0] wq[$];
    rexp_t      re;
    logic [1:0] we;
    int checks = 0, failures = 0;
    int cnt_ar[3] = '{0, 0, 0};
    int cnt_aw[3] = '{0, 0, 0};
    int cnt_w[3] = '{0, 0, 0};
    int maw_cnt = 0, mw_cnt = 0;
    int rd_lat = 1;
    int lat_cnt[3];
    logic [31:0] lw_addr[3], lw_data[3];
    logic [3:0]  lw_strb[3];
    logic [2:0]  pend, aw_got, w_got;
    logic        sa, sw;

    task automatic ck(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Behavioural slaves: always ready, R after rd_lat cycles, B the cycle after AW and W both land.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sif.rvalid <= '0;
            sif.bvalid <= '0;
            pend       <= '0;
            aw_got     <= '0;
            w_got      <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sif.arvalid[i] && sif.arready[i]) begin
                    cnt_ar[i]  <= cnt_ar[i] + 1;
                    lat_cnt[i] <= rd_lat - 1;
                    pend[i]    <= 1'b1;
                end else if (pend[i]) begin
                    if (lat_cnt[i] == 0) begin
                        sif.rvalid[i] <= 1'b1;
                        pend[i]       <= 1'b0;
                    end else lat_cnt[i] <= lat_cnt[i] - 1;
                end
                if (sif.rvalid[i] && sif.rready[i]) sif.rvalid[i] <= 1'b0;
                sa = aw_got[i] | (sif.awvalid[i] & sif.awready[i]);
                sw = w_got[i] | (sif.wvalid[i] & sif.wready[i]);
                if (sif.awvalid[i] && sif.awready[i]) begin
                    cnt_aw[i]  <= cnt_aw[i] + 1;
                    lw_addr[i] <= sif.awaddr;
                end
                if (sif.wvalid[i] && sif.wready[i]) begin
                    cnt_w[i]   <= cnt_w[i] + 1;
                    lw_data[i] <= sif.wdata;
                    lw_strb[i] <= sif.wstrb;
                end
                if (sa && sw) begin
                    sif.bvalid[i] <= 1'b1;
                    aw_got[i]     <= 1'b0;
                    w_got[i]      <= 1'b0;
                end else begin
                    aw_got[i] <= sa;
                    w_got[i]  <= sw;
                end
                if (sif.bvalid[i] && sif.bready[i]) sif.bvalid[i] <= 1'b0;
            end
        end
    end

    // Scoreboard side: pop on every master-side R/B handshake.
    always @(negedge clk) begin
        maw_cnt += int'(mif.awready);
        mw_cnt  += int'(mif.wready);
        if (mif.rvalid && mif.rready) begin
            if (rq.size() == 0) begin
                checks++; failures++;
                $display("FAIL r_unexpected: got rdata %0h with no read outstanding", mif.rdata);
            end else begin
                re = rq.pop_front();
                ck("r_data_resp", {mif.rdata, mif.rresp}, {re.data, re.resp});
            end
        end
        if (mif.bvalid && mif.bready) begin
            if (wq.size() == 0) begin
                checks++; failures++;
                $display("FAIL b_unexpected: got bresp %0h with no write outstanding", mif.bresp);
            end else begin
                we = wq.pop_front();
                ck("b_resp", mif.bresp, we);
            end
        end
    end

    function automatic logic sig(input int w);
        return w == 0 ? mif.arready[0] : w == 1 ? mif.rvalid[0] : w == 2 ? mif.awready[0] :
               w == 3 ? mif.wready[0] : mif.bvalid[0];
    endfunction

    function automatic logic [2:0] delta(input int now[3], input int b[3]);
        logic [2:0] r;
        for (int i = 0; i < 3; i++) r[i] = now[i] != b[i];
        return r;
    endfunction

    function automatic logic [2:0] oh(input int es);
        return es < 0 ? 3'b000 : 3'(1 << es);
    endfunction

    task automatic wait_sig(input int w, input string nm);
        int n = 0;
        @(negedge clk);
        while (!sig(w)) begin
            if (n++ == 60) begin
                checks++; failures++;
                $display("FAIL timeout_%s: got no assertion in 60 cycles, expected it asserted", nm);
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input int lat, input int rdelay,
                           input logic [31:0] xdata, input logic [1:0] xresp, input int es);
        int b[3] = cnt_ar;
        rd_lat = lat;
        rq.push_back(rexp_t'{xdata, xresp});
        mif.araddr  = addr;
        mif.arvalid = 1'b1;
        mif.rready  = 1'b0;
        wait_sig(0, "arready");
        @(posedge clk); #1;
        mif.arvalid = 1'b0;
        mif.rready  = rdelay == 0;
        for (int k = 0; k < rdelay; k++) begin
            @(negedge clk);
            ck("r_hold", {mif.rvalid, mif.rdata, mif.rresp}, {1'b1, xdata, xresp});
        end
        if (rdelay > 0) begin
            @(posedge clk); #1;
            mif.rready = 1'b1;
        end
        wait_sig(1, "rvalid");
        @(posedge clk); #1;
        mif.rready = 1'b0;
        @(negedge clk);
        ck("r_done_idle", {mif.rvalid, mif.arready}, 0);
        ck("ar_route", delta(cnt_ar, b), oh(es));
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int wd, input logic [1:0] xresp, input int es);
        int baw[3] = cnt_aw;
        int bw[3] = cnt_w;
        wq.push_back(xresp);
        mif.awaddr = addr;
        mif.wdata  = data;
        mif.wstrb  = strb;
        mif.bready = 1'b1;
        fork
            begin
                repeat (wd < 0 ? -wd : 0) begin @(posedge clk); #1; end
                mif.awvalid = 1'b1;
                wait_sig(2, "awready");
                @(posedge clk); #1;
                mif.awvalid = 1'b0;
            end
            begin
                repeat (wd > 0 ? wd : 0) begin @(posedge clk); #1; end
                mif.wvalid = 1'b1;
                wait_sig(3, "wready");
                if (wd > 0) ck("aw_masked", sif.awvalid, 0);
                @(posedge clk); #1;
                mif.wvalid = 1'b0;
            end
        join
        wait_sig(4, "bvalid");
        @(posedge clk); #1;
        mif.bready = 1'b0;
        @(negedge clk);
        ck("b_done_idle", mif.bvalid, 0);
        ck("aw_route", delta(cnt_aw, baw), oh(es));
        ck("w_route", delta(cnt_w, bw), oh(es));
        if (es >= 0) ck("wr_payload", {lw_addr[es], lw_data[es], lw_strb[es]}, {addr, data, strb});
    endtask

    initial begin
        vec_t vt[10];
        int b2, ba, bw;
        vt[0] = '{1'b0, 32'h8000_0004, 32'h0, 4'h0, 3, 0, 32'hDEAD_BEEF, 2'b00};
        vt[1] = '{1'b0, 32'hA000_03FC, 32'h0, 4'h0, 1, 1, 32'h1111_0001, 2'b00};
        vt[2] = '{1'b0, 32'hA000_0048, 32'h0, 4'h0, 2, 2, 32'h2222_0002, 2'b10};
        vt[3] = '{1'b0, 32'h0000_1000, 32'h0, 4'h0, 1, -1, 32'h0, 2'b11};
        vt[4] = '{1'b0, 32'h87FF_FFFC, 32'h0, 4'h0, 1, 0, 32'hDEAD_BEEF, 2'b00};
        vt[5] = '{1'b0, 32'h8800_0000, 32'h0, 4'h0, 1, -1, 32'h0, 2'b11};
        vt[6] = '{1'b1, 32'h8123_4560, 32'hCAFE_F00D, 4'hF, 0, 0, 32'h0, 2'b00};
        vt[7] = '{1'b1, 32'hA000_004C, 32'h0000_5A5A, 4'h3, 0, 2, 32'h0, 2'b10};
        vt[8] = '{1'b1, 32'hA000_0050, 32'h1234_5678, 4'hF, 0, -1, 32'h0, 2'b11};
        vt[9] = '{1'b1, 32'hA000_03F8, 32'h0000_0041, 4'h1, 0, 1, 32'h0, 2'b00};
        mif.arvalid = 0; mif.araddr = 0; mif.rready = 0; mif.awvalid = 0; mif.awaddr = 0;
        mif.wvalid = 0; mif.wdata = 0; mif.wstrb = 0; mif.bready = 0;
        sif.arready = '1; sif.awready = '1; sif.wready = '1;
        sif.rdata = {32'h2222_0002, 32'h1111_0001, 32'hDEAD_BEEF};
        sif.rresp = {2'b10, 2'b00, 2'b00};
        sif.bresp = {2'b10, 2'b00, 2'b00};
        rst_n = 1'b0;
        #1;
        ck("reset_outputs", {mif.arready, mif.rvalid, mif.rdata, mif.rresp, mif.awready, mif.wready,
                             mif.bvalid, mif.bresp, sif.arvalid, sif.rready, sif.awvalid, sif.wvalid,
                             sif.bready}, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (vt[i].wr) do_write(vt[i].addr, vt[i].wdata, vt[i].wstrb, 0, vt[i].resp, vt[i].es);
            else do_read(vt[i].addr, vt[i].lat, 0, vt[i].rdata, vt[i].resp, vt[i].es);
        end
        // AW two cycles ahead of W to slave1.
        @(posedge clk); #1;
        do_write(32'hA000_03F8, 32'h0000_0041, 4'b0001, 2, 2'b00, 1);
        // Unmapped read with R held off for 5 cycles.
        @(posedge clk); #1;
        do_read(32'h0000_1000, 1, 5, 32'h0, 2'b11, -1);
        // Read and write arrive together: the write must finish before slave2 sees AR.
        @(posedge clk); #1;
        b2 = cnt_ar[2];
        fork
            begin
                do_write(32'h8000_0000, 32'h55AA_33CC, 4'hF, 0, 2'b00, 0);
                ck("write_before_read", cnt_ar[2], b2);
            end
            do_read(32'hA000_0048, 2, 0, 32'h2222_0002, 2'b10, 2);
        join
        // Unmapped write with W one cycle ahead of AW.
        @(posedge clk); #1;
        ba = maw_cnt;
        bw = mw_cnt;
        do_write(32'h9000_0000, 32'hFFFF_0000, 4'hF, -1, 2'b11, -1);
        @(posedge clk); #1;
        ck("err_awready_pulses", maw_cnt - ba, 1);
        ck("err_wready_pulses", mw_cnt - bw, 1);
        // Asynchronous reset while R is pending on slave0.
        @(posedge clk); #1;
        rd_lat = 3;
        mif.araddr = 32'h8000_0004;
        mif.arvalid = 1'b1;
        mif.rready = 1'b0;
        wait_sig(0, "arready_rst");
        @(posedge clk); #1;
        mif.arvalid = 1'b0;
        wait_sig(1, "rvalid_rst");
        ck("rvalid_before_reset", mif.rvalid, 1);
        #2 rst_n = 1'b0;
        #1;
        ck("async_reset_clears", {mif.arready, mif.rvalid, mif.awready, mif.wready, mif.bvalid,
                                  sif.arvalid, sif.rready, sif.awvalid, sif.wvalid, sif.bready}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        do_read(32'h8000_0004, 3, 0, 32'hDEAD_BEEF, 2'b00, 0);
        ck("rq_drained", rq.size(), 0);
        ck("wq_drained", wq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
